// File: rtl/dcache_controller_pkg.sv
// Shared widths, FSM state encoding and line layout for the L1 data-cache controller.
package dcache_controller_pkg;
  localparam int unsigned BLOCK_BITS  = 1024;
  localparam int unsigned OFFSET_BITS = 7;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned MASK_BITS   = BLOCK_BITS / 8;
  localparam int unsigned BYTE_SEL_W  = 2;
  localparam int unsigned WORD_LSB_W  = 5;
  localparam int unsigned LINE_TAG_W  = ADDR_W - OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE,
    RLOOK,
    WLOOK,
    RREPAIR,
    WREPAIR
  } dc_state_t;

  // The tag field keeps the whole block address; the index bits inside it always match.
  typedef struct packed {
    logic                  valid;
    logic [LINE_TAG_W-1:0] tag;
    logic [BLOCK_BITS-1:0] data;
  } dc_line_t;
endpackage

// File: rtl/dcache_controller_if.sv
// Arbiter-side request, response and repair handshake bundle of the data cache.
interface dcache_controller_if;
  import dcache_controller_pkg::*;

  logic                  req_ready;
  logic                  raddr_valid;
  logic [ADDR_W-1:0]     raddr;
  logic                  rdata_valid;
  logic [WORD_BITS-1:0]  rdata;
  logic                  waddr_valid;
  logic [ADDR_W-1:0]     waddr;
  logic [BLOCK_BITS-1:0] wdata;
  logic [MASK_BITS-1:0]  wmask;
  logic                  read_repair_request;
  logic [ADDR_W-1:0]     missed_raddr;
  logic                  write_repair_request;
  logic [ADDR_W-1:0]     missed_waddr;
  logic                  read_repair_req_acq;
  logic                  write_repair_req_acq;
  logic                  repair_resolved;

  modport slave (
    output req_ready, rdata_valid, rdata, read_repair_request, missed_raddr,
           write_repair_request, missed_waddr,
    input  raddr_valid, raddr, waddr_valid, waddr, wdata, wmask,
           read_repair_req_acq, write_repair_req_acq, repair_resolved
  );

  modport master (
    input  req_ready, rdata_valid, rdata, read_repair_request, missed_raddr,
           write_repair_request, missed_waddr,
    output raddr_valid, raddr, waddr_valid, waddr, wdata, wmask,
           read_repair_req_acq, write_repair_req_acq, repair_resolved
  );
endinterface

// File: rtl/dcache_line_array.sv
// Direct-mapped tag/valid/data storage: combinational lookup, byte-masked block write port.
module dcache_line_array
  import dcache_controller_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINE_TAG_W-1:0] lk_blk,
  output logic                  hit,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic                  wr_fill,
  input  logic [LINE_TAG_W-1:0] wr_blk,
  input  logic [BLOCK_BITS-1:0] wr_data,
  input  logic [MASK_BITS-1:0]  wr_mask
);
  localparam int unsigned IDX_W = $clog2(SETS);

  logic [SETS-1:0]       valid_q;
  logic [LINE_TAG_W-1:0] tag_q  [SETS];
  logic [BLOCK_BITS-1:0] data_q [SETS];
  logic [IDX_W-1:0]      lk_idx;
  logic [IDX_W-1:0]      wr_idx;
  dc_line_t              rd_line;

  assign lk_idx  = lk_blk[IDX_W-1:0];
  assign wr_idx  = wr_blk[IDX_W-1:0];
  assign rd_line = '{valid: valid_q[lk_idx], tag: tag_q[lk_idx], data: data_q[lk_idx]};
  assign hit     = rd_line.valid && (rd_line.tag == lk_blk);
  assign rd_data = rd_line.data;

  // Only valid bits are reset; tags and data are don't-care until a fill lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_fill) tag_q[wr_idx] <= wr_blk;
      for (int unsigned b = 0; b < MASK_BITS; b++) begin
        if (wr_mask[b]) data_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped L1 data-cache controller with read/write repair handshakes toward the L2 arbiter.
// Optional DCACHE_STATS_EN adds hit_count/miss_count lookup statistics.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input  logic clk,
  input  logic rst,
  dcache_controller_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  dc_state_t             state, state_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d, waddr_q, waddr_d;
  logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
  logic [MASK_BITS-1:0]  wmask_q, wmask_d;
  logic                  racq, racq_d, wacq, wacq_d;
  logic                  req_ready_d, rdata_valid_d, rrr_d, wrr_d;
  logic [WORD_BITS-1:0]  rdata_d;
  logic [ADDR_W-1:0]     missed_raddr_d, missed_waddr_d;

  logic                  hit;
  logic [BLOCK_BITS-1:0] rd_data;
  logic [LINE_TAG_W-1:0] lk_blk;
  logic                  wr_en, wr_fill;
  logic [LINE_TAG_W-1:0] wr_blk;
  logic [BLOCK_BITS-1:0] wr_data;
  logic [MASK_BITS-1:0]  wr_mask;

  assign lk_blk = (state == WLOOK) ? waddr_q[ADDR_W-1:OFFSET_BITS] : raddr_q[ADDR_W-1:OFFSET_BITS];

  dcache_line_array #(.SETS(SETS)) u_lines (
    .clk     (clk),
    .rst     (rst),
    .lk_blk  (lk_blk),
    .hit     (hit),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_fill (wr_fill),
    .wr_blk  (wr_blk),
    .wr_data (wr_data),
    .wr_mask (wr_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                    <= IDLE;
      raddr_q                  <= '0;
      waddr_q                  <= '0;
      wdata_q                  <= '0;
      wmask_q                  <= '0;
      racq                     <= 1'b0;
      wacq                     <= 1'b0;
      bus.req_ready            <= 1'b0;
      bus.rdata_valid          <= 1'b0;
      bus.rdata                <= '0;
      bus.read_repair_request  <= 1'b0;
      bus.missed_raddr         <= '0;
      bus.write_repair_request <= 1'b0;
      bus.missed_waddr         <= '0;
    end else begin
      state                    <= state_d;
      raddr_q                  <= raddr_d;
      waddr_q                  <= waddr_d;
      wdata_q                  <= wdata_d;
      wmask_q                  <= wmask_d;
      racq                     <= racq_d;
      wacq                     <= wacq_d;
      bus.req_ready            <= req_ready_d;
      bus.rdata_valid          <= rdata_valid_d;
      bus.rdata                <= rdata_d;
      bus.read_repair_request  <= rrr_d;
      bus.missed_raddr         <= missed_raddr_d;
      bus.write_repair_request <= wrr_d;
      bus.missed_waddr         <= missed_waddr_d;
    end
  end

  // Next state, array write control and next-cycle output values.
  always_comb begin
    state_d       = state;
    raddr_d       = raddr_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    racq_d        = racq;
    wacq_d        = wacq;
    rdata_valid_d = 1'b0;
    rdata_d       = bus.rdata;
    wr_en         = 1'b0;
    wr_fill       = 1'b0;
    wr_blk        = waddr_q[ADDR_W-1:OFFSET_BITS];
    wr_data       = wdata_q;
    wr_mask       = wmask_q;

    case (state)
      IDLE: begin
        if (bus.req_ready && bus.raddr_valid) begin
          raddr_d = bus.raddr;
          state_d = RLOOK;
        end else if (bus.req_ready && bus.waddr_valid) begin
          waddr_d = bus.waddr;
          wdata_d = bus.wdata;
          wmask_d = bus.wmask;
          state_d = WLOOK;
        end
      end
      RLOOK: begin
        if (hit) begin
          rdata_valid_d = 1'b1;
          rdata_d       = rd_data[{raddr_q[OFFSET_BITS-1:BYTE_SEL_W], WORD_LSB_W'(0)} +: WORD_BITS];
          state_d       = IDLE;
        end else begin
          state_d = RREPAIR;
        end
      end
      WLOOK: begin
        if (hit) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WREPAIR;
        end
      end
      // Completion needs this channel's own acceptance, so the other channel cannot end it.
      RREPAIR: begin
        racq_d = racq | bus.read_repair_req_acq;
        if (bus.repair_resolved && racq) begin
          racq_d  = 1'b0;
          state_d = RLOOK;
        end
      end
      WREPAIR: begin
        wacq_d = wacq | bus.write_repair_req_acq;
        if (bus.repair_resolved && wacq) begin
          wacq_d  = 1'b0;
          state_d = WLOOK;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state == RREPAIR || state == WREPAIR) && bus.waddr_valid && (&bus.wmask)) begin
      wr_en   = 1'b1;
      wr_fill = 1'b1;
      wr_blk  = bus.waddr[ADDR_W-1:OFFSET_BITS];
      wr_data = bus.wdata;
      wr_mask = bus.wmask;
    end

    req_ready_d    = (state_d == IDLE);
    rrr_d          = (state_d == RREPAIR);
    wrr_d          = (state_d == WREPAIR);
    missed_raddr_d = rrr_d ? raddr_q : '0;
    missed_waddr_d = wrr_d ? waddr_q : '0;
  end

`ifdef DCACHE_STATS_EN
  logic replay_q;

  // Lookups re-entered from a repair are replays and are not counted again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if ((state == RLOOK || state == WLOOK) && !replay_q) begin
        if (hit) hit_count  <= hit_count + 32'd1;
        else     miss_count <= miss_count + 32'd1;
      end
      if ((state == RREPAIR || state == WREPAIR) && (state_d == RLOOK || state_d == WLOOK))
        replay_q <= 1'b1;
      else if (state_d == IDLE)
        replay_q <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Directed plus randomized bench for dcache_controller against a line-level cache model.
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  dcache_controller_if bus ();

  dcache_controller #(.SETS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: each set remembers whether it holds a block, which block (addr >> 7), and its bytes.
  bit          m_valid [16];
  logic [24:0] m_blk   [16];
  logic [1023:0] m_data [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 7) % 16);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[set_of(a)] && (m_blk[set_of(a)] == 25'(a >> 7));
  endfunction

  function automatic logic [31:0] word_of(input logic [1023:0] b, input logic [31:0] a);
    int w;
    w = int'((a % 128) / 4);
    return 32'(b >> (32 * w));
  endfunction

  function automatic logic [1023:0] rand_block();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [127:0] rand_mask();
    logic [127:0] m;
    for (int i = 0; i < 4; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic model_merge(input logic [31:0] a, input logic [1023:0] b, input logic [127:0] m);
    for (int i = 0; i < 128; i++)
      if (m[i]) m_data[set_of(a)][i*8 +: 8] = b[i*8 +: 8];
  endtask

  task automatic idle_inputs();
    bus.raddr_valid          = 1'b0;
    bus.raddr                = '0;
    bus.waddr_valid          = 1'b0;
    bus.waddr                = '0;
    bus.wdata                = '0;
    bus.wmask                = '0;
    bus.read_repair_req_acq  = 1'b0;
    bus.write_repair_req_acq = 1'b0;
    bus.repair_resolved      = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
    check("req_ready_timeout", 64'(bus.req_ready), 64'd1);
  endtask

  // Own acceptance, a full-mask fill of the missed block, then resolution.
  task automatic serve_repair(input bit is_read, input logic [31:0] a, input logic [1023:0] fill);
    if (is_read) bus.read_repair_req_acq = 1'b1;
    else         bus.write_repair_req_acq = 1'b1;
    tick();
    bus.read_repair_req_acq  = 1'b0;
    bus.write_repair_req_acq = 1'b0;
    bus.waddr_valid = 1'b1;
    bus.waddr       = a;
    bus.wdata       = fill;
    bus.wmask       = '1;
    tick();
    bus.waddr_valid = 1'b0;
    check(is_read ? "rreq_held_before_resolve" : "wreq_held_before_resolve",
          64'(is_read ? bus.read_repair_request : bus.write_repair_request), 64'd1);
    bus.repair_resolved = 1'b1;
    tick();
    bus.repair_resolved = 1'b0;
    check(is_read ? "rreq_drop" : "wreq_drop",
          64'(is_read ? bus.read_repair_request : bus.write_repair_request), 64'd0);
    m_valid[set_of(a)] = 1'b1;
    m_blk[set_of(a)]   = 25'(a >> 7);
    m_data[set_of(a)]  = fill;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1023:0] fill);
    bit h;
    wait_ready();
    h = model_hit(a);
    bus.raddr_valid = 1'b1;
    bus.raddr       = a;
    tick();
    bus.raddr_valid = 1'b0;
    tick();
    check("rd_valid_on_lookup", 64'(bus.rdata_valid), 64'(h));
    check("rd_repair_req", 64'(bus.read_repair_request), 64'(!h));
    if (!h) begin
      check("missed_raddr", 64'(bus.missed_raddr), 64'(a));
      serve_repair(1'b1, a, fill);
      tick();
      check("rd_valid_after_repair", 64'(bus.rdata_valid), 64'd1);
    end
    check("rdata", 64'(bus.rdata), 64'(word_of(m_data[set_of(a)], a)));
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [1023:0] b, input logic [127:0] m, output bit h);
    wait_ready();
    h = model_hit(a);
    bus.waddr_valid = 1'b1;
    bus.waddr       = a;
    bus.wdata       = b;
    bus.wmask       = m;
    tick();
    bus.waddr_valid = 1'b0;
    tick();
    check("wr_repair_req", 64'(bus.write_repair_request), 64'(!h));
    if (!h) check("missed_waddr", 64'(bus.missed_waddr), 64'(a));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1023:0] b, input logic [127:0] m);
    bit h;
    issue_write(a, b, m, h);
    if (!h) begin
      serve_repair(1'b0, a, rand_block());
      tick();
    end
    model_merge(a, b, m);
  endtask

  initial begin
    logic [31:0]   pool [6];
    logic [31:0]   a;
    logic [1023:0] b;
    logic [127:0]  m;
    bit            h;

    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rdata_valid", 64'(bus.rdata_valid), 64'd0);
    check("rst_rreq", 64'(bus.read_repair_request), 64'd0);
    check("rst_wreq", 64'(bus.write_repair_request), 64'd0);
    rst = 1'b0;
    tick();

    // Read miss with an all-ones fill, then a plain hit.
    do_read(32'hAABB_CCDD, '1);
    check("ones_word", 64'(bus.rdata), 64'hFFFF_FFFF);
    do_read(32'hAABB_CCDD, rand_block());

    // Full-mask write hit followed by a read of the new word.
    do_write(32'hAABB_CCDD, rand_block(), '1);
    do_read(32'hAABB_CCDD, rand_block());
    do_read(32'hAABB_CC80, rand_block());

    // Write miss: read-channel acceptance and resolutions must not finish it.
    b = rand_block();
    m = rand_mask();
    issue_write(32'h0000_0001, b, m, h);
    bus.read_repair_req_acq = 1'b1;
    tick();
    bus.read_repair_req_acq = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.repair_resolved = 1'((i + 1) % 2);
      tick();
      check("wreq_cross_hold", 64'(bus.write_repair_request), 64'd1);
    end
    bus.repair_resolved = 1'b0;
    check("wreq_cross_rreq_low", 64'(bus.read_repair_request), 64'd0);
    serve_repair(1'b0, 32'h0000_0001, rand_block());
    tick();
    model_merge(32'h0000_0001, b, m);
    do_read(32'h0000_0040, rand_block());

    // Read miss: write-channel acceptance must not finish it; reset lands mid-repair.
    wait_ready();
    bus.raddr_valid = 1'b1;
    bus.raddr       = 32'h1234_5600;
    tick();
    bus.raddr_valid = 1'b0;
    tick();
    check("rreq_cross_start", 64'(bus.read_repair_request), 64'd1);
    bus.write_repair_req_acq = 1'b1;
    tick();
    bus.write_repair_req_acq = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.repair_resolved = 1'((i + 1) % 2);
      tick();
      check("rreq_cross_hold", 64'(bus.read_repair_request), 64'd1);
      check("rreq_cross_no_data", 64'(bus.rdata_valid), 64'd0);
    end
    bus.repair_resolved = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    check("midrst_rreq", 64'(bus.read_repair_request), 64'd0);
    check("midrst_missed_raddr", 64'(bus.missed_raddr), 64'd0);
    check("midrst_wreq", 64'(bus.write_repair_request), 64'd0);
    check("midrst_rdata", {31'd0, bus.rdata_valid, bus.rdata}, 64'd0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_read(32'hAABB_CCDD, rand_block());

    // Random mix over blocks that share sets, so evictions and refills occur.
    pool[0] = 32'h0000_0180;
    pool[1] = 32'h7000_0180;
    pool[2] = 32'h0000_0280;
    pool[3] = 32'hAABB_CC80;
    pool[4] = 32'h5555_5480;
    pool[5] = 32'h0000_0000;
    for (int n = 0; n < 60; n++) begin
      a = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) begin
        m = ($urandom_range(0, 3) == 0) ? '1 : rand_mask();
        do_write(a, rand_block(), m);
      end else begin
        do_read(a, rand_block());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped L1 data-cache controller with 1024-bit (128-byte) blocks.
- Holds tag, valid and data arrays and serves one read or one block write at a time from the memory arbiter side.
- On a miss it raises a read- or write-repair request toward the arbiter, then waits for the fill and the resolution handshake.
- Sits between the core load/store path (via the arbiter) and the L2 arbiter.

Parameters:
- SETS, 16: number of cache lines; power of two. Index = addr[6+log2(SETS):7].
- ADDR_W, 32: address width. Tag = addr[ADDR_W-1:7+log2(SETS)].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_ready  out  1  high in IDLE; requests are accepted only when high.
- raddr_valid  in  1  read request strobe.
- raddr  in  32  read byte address.
- rdata_valid  out  1  one-cycle pulse when rdata is valid.
- rdata  out  32  word at raddr[6:2] of the hit block.
- waddr_valid  in  1  block write strobe; used for both core writes and repair fills.
- waddr  in  32  write address.
- wdata  in  1024  write block data.
- wmask  in  128  byte enables for wdata.
- read_repair_request  out  1  read miss pending.
- missed_raddr  out  32  address of the pending read miss.
- write_repair_request  out  1  write miss pending.
- missed_waddr  out  32  address of the pending write miss.
- read_repair_req_acq  in  1  arbiter accepted the read repair.
- write_repair_req_acq  in  1  arbiter accepted the write repair.
- repair_resolved  in  1  arbiter finished the repair it accepted.

Behaviour:
- Reset: state IDLE; all valid bits cleared; all outputs 0; acq flags cleared. Data and tag arrays are not reset.
- States: IDLE, RLOOK, WLOOK, RREPAIR, WREPAIR.
- IDLE accept:
  - raddr_valid: register raddr, go RLOOK.
  - Else waddr_valid: register waddr, wdata, wmask, go WLOOK.
  - Read has priority. A simultaneous write is dropped; the sender must retry while req_ready is high.
- RLOOK:
  - Hit (valid && tag match): rdata_valid=1 and rdata=word[raddr[6:2]] for one cycle, then IDLE. Load-to-data latency is 2 cycles.
  - Miss: go RREPAIR.
- WLOOK:
  - Hit: bytes with wmask=1 merged into the line that cycle, then IDLE. No request is raised.
  - Miss: go WREPAIR.
- RREPAIR:
  - read_repair_request=1 and missed_raddr=registered raddr every cycle, from the cycle after the miss until exit.
  - read_repair_req_acq sets sticky flag racq.
- WREPAIR: mirror of RREPAIR using write_repair_request, missed_waddr and flag wacq.
- Fill, in either repair state only: waddr_valid with a full wmask writes wdata into line index(waddr), sets its tag from waddr and valid=1. Acceptance does not depend on the acq flags.
- Exit from repair:
  - Taken on repair_resolved && own acq flag (racq in RREPAIR, wacq in WREPAIR), sampled at the clock edge.
  - repair_resolved without the own flag is ignored. The other channel's acq is ignored. This stops one channel's resolution from falsely completing the other's repair.
  - RREPAIR exit: go RLOOK again (the replay hits and returns data).
  - WREPAIR exit: go WLOOK again (the replay merges the saved write).
  - On exit the request output drops and the acq flag clears.
- Asserting rst in any state returns to IDLE at once and drops all requests.

Optional Feature:
- DCACHE_STATS_EN defined: adds output ports hit_count[31:0] and miss_count[31:0].
  - Reset to 0.
  - Incremented once per first-time lookup in RLOOK/WLOOK; replays after a repair are not counted.
  - Counters wrap modulo 2^32.
- DCACHE_STATS_EN undefined: the ports and the counter logic are absent.

Decomposition:
- CORE_PKG holds: BLOCK_BITS=1024, OFFSET_BITS=7, WORD_BITS=32, the state enum dc_state_t, and the line struct {valid, tag, data}.
- One sub-module, dcache_line_array: tag, valid and data storage with combinational hit compare and a byte-masked write port.

Test Plan:
- Read miss to 0xAABB_CCDD → read_repair_request=1 and missed_raddr=0xAABB_CCDD two edges after the request. Then acq plus a fill with all-ones wdata/wmask, then repair_resolved → request drops, one rdata_valid pulse with rdata=0xFFFF_FFFF.
- Read hit after that fill → rdata_valid two cycles after raddr_valid; read_repair_request stays 0.
- Write hit to 0xAABB_CCDD with new block and wmask='1 → write_repair_request stays 0; a following read returns the new word.
- Read miss, then only write_repair_req_acq with repair_resolved toggling for 11 cycles → read_repair_request remains 1 and state stays RREPAIR.
- Write miss to 0x0000_0001, then read_repair_req_acq with repair_resolved toggling → write_repair_request remains 1.
- rst asserted mid-RREPAIR → all outputs 0 immediately; a read to the previously filled line now misses.
